pipe_reg_chain: RTL and testbench

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

---
 rtl/pipe_reg_chain.sv | 106 ++++++++++
 tb/tb_pipe_reg_chain.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - valid/ready register chain with bubble collapse, flush and occupancy count
module pipe_reg_chain #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [WIDTH-1:0]             in_data_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [WIDTH-1:0]             out_data_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int CW = $clog2(DEPTH + 1);

   generate
      if (DEPTH < 1) begin : g_depth_check
         $error("pipe_reg_chain: DEPTH must be >= 1");
      end
   endgenerate

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;
   logic [WIDTH-1:0] d_q   [DEPTH];
   logic [WIDTH-1:0] d_d   [DEPTH];
   logic [WIDTH-1:0] src_d [DEPTH];
   logic [DEPTH:0]   rdy;
   logic [DEPTH-1:0] src_v;
   logic [CW-1:0]    cnt;

   // rdy[k]: stage k can take an item this cycle, looking through every stage that will drain
   always_comb begin
      logic r;
      r          = out_ready_i;
      rdy        = '0;
      rdy[DEPTH] = out_ready_i;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         r      = !v_q[k] || r;
         rdy[k] = r;
      end
   end

   assign src_v = DEPTH'({v_q, in_valid_i});

   always_comb begin
      src_d[0] = in_data_i;
      for (int k = 1; k < DEPTH; k++) begin
         src_d[k] = d_q[k-1];
      end
   end

   always_comb begin
      logic ld;
      logic lv;
      v_d = v_q;
      for (int k = 0; k < DEPTH; k++) begin
         d_d[k] = d_q[k];
      end
      for (int k = 0; k < DEPTH; k++) begin
         ld = !flush_i && src_v[k] && rdy[k];
         lv = !flush_i && v_q[k] && rdy[k+1];
         if (flush_i) begin
            v_d[k] = 1'b0;
         end else if (ld) begin
            v_d[k] = 1'b1;
         end else if (lv) begin
            v_d[k] = 1'b0;
         end
         if (ld) begin
            d_d[k] = src_d[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         v_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= RESET_VAL;
         end
      end else begin
         v_q <= v_d;
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= d_d[k];
         end
      end
   end

   always_comb begin
      cnt = '0;
      for (int k = 0; k < DEPTH; k++) begin
         cnt = cnt + CW'(v_q[k]);
      end
   end

   assign in_ready_o  = rdy[0] && !flush_i;
   assign out_valid_o = v_q[DEPTH-1] && !flush_i;
   assign out_data_o  = d_q[DEPTH-1];
   assign count_o     = cnt;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - randomized and directed bench for pipe_reg_chain against a positional queue model
module tb_pipe_reg_chain;

   localparam int D = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic [1:0] count;

   logic       d1_flush = 1'b0;
   logic       d1_in_valid = 1'b0;
   logic       d1_in_ready;
   logic [7:0] d1_in_data = 8'h00;
   logic       d1_out_valid;
   logic       d1_out_ready = 1'b0;
   logic [7:0] d1_out_data;
   logic [0:0] d1_count;

   always #5 clk = ~clk;

   pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_dut (
      .clk(clk), .rst_ni(rst_n), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .count_o(count)
   );

   pipe_reg_chain #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h5C)) u_dut1 (
      .clk(clk), .rst_ni(rst_n), .flush_i(d1_flush),
      .in_valid_i(d1_in_valid), .in_ready_o(d1_in_ready), .in_data_i(d1_in_data),
      .out_valid_o(d1_out_valid), .out_ready_i(d1_out_ready), .out_data_o(d1_out_data),
      .count_o(d1_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Model: items oldest-first, each with the stage position it occupies
   int         mpos[$];
   logic [7:0] mdat[$];
   logic [7:0] last_out = 8'h00;
   int         cyc = 0;
   int         obs_cyc[$];
   logic [7:0] obs_dat[$];
   logic       s_ir, s_ov, s_acc;
   logic [7:0] s_od;
   logic [1:0] s_cnt;

   task automatic step(input logic iv, input logic [7:0] id, input logic orr, input logic fl);
      bit         moved[$];
      bit         free0;
      bit         exp_ov;
      int         n;
      int         npos[$];
      logic [7:0] ndat[$];
      @(negedge clk);
      in_valid  = iv;
      in_data   = id;
      out_ready = orr;
      flush     = fl;
      #1;
      n = mpos.size();
      for (int i = 0; i < n; i++) begin
         bit m;
         if (fl)          m = 1'b0;
         else if (i == 0) m = (mpos[0] == D - 1) ? orr : 1'b1;
         else             m = (mpos[i-1] != mpos[i] + 1) || moved[i-1];
         moved.push_back(m);
      end
      if (n == 0)                 free0 = 1'b1;
      else                        free0 = (mpos[n-1] != 0) || moved[n-1];
      exp_ov = 1'b0;
      if (!fl && n > 0) exp_ov = (mpos[0] == D - 1);
      s_ir  = in_ready;
      s_ov  = out_valid;
      s_od  = out_data;
      s_cnt = count;
      check_eq("count", 32'(s_cnt), 32'(n));
      check_eq("out_valid", 32'(s_ov), 32'(exp_ov));
      if (!fl) check_eq("out_data", 32'(s_od), 32'(last_out));
      check_eq("in_ready", 32'(s_ir), 32'(!fl && free0));
      s_acc = iv && !fl && free0;
      if (s_ov && orr) begin
         obs_cyc.push_back(cyc);
         obs_dat.push_back(s_od);
      end
      @(posedge clk);
      if (fl) begin
         mpos.delete();
         mdat.delete();
      end else begin
         for (int i = 0; i < n; i++) begin
            if (moved[i] && mpos[i] == D - 1) continue;
            if (moved[i] && mpos[i] + 1 == D - 1) last_out = mdat[i];
            npos.push_back(mpos[i] + (moved[i] ? 1 : 0));
            ndat.push_back(mdat[i]);
         end
         if (s_acc) begin
            npos.push_back(0);
            ndat.push_back(id);
         end
         mpos = npos;
         mdat = ndat;
      end
      cyc++;
   endtask

   initial begin
      int c11;
      logic [7:0] exp_seq [4];
      #12;
      check_eq("rst_out_valid", 32'(out_valid), 32'h0);
      check_eq("rst_out_data", 32'(out_data), 32'h00);
      check_eq("rst_count", 32'(count), 32'h0);
      check_eq("rst_in_ready", 32'(in_ready), 32'h1);
      check_eq("d1_rst_out_data", 32'(d1_out_data), 32'h5C);
      check_eq("d1_rst_in_ready", 32'(d1_in_ready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;

      // Streaming with the sink always ready
      obs_cyc.delete();
      obs_dat.delete();
      exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
      c11 = cyc;
      for (int k = 0; k < 4; k++) begin
         step(1'b1, exp_seq[k], 1'b1, 1'b0);
         check_eq("stream_accept", 32'(s_acc), 32'h1);
      end
      for (int k = 0; k < 5; k++) step(1'b0, 8'hEE, 1'b1, 1'b0);
      check_eq("stream_count", 32'(obs_dat.size()), 32'd4);
      for (int k = 0; k < 4 && k < obs_dat.size(); k++) begin
         check_eq("stream_data", 32'(obs_dat[k]), 32'(exp_seq[k]));
         check_eq("stream_latency", 32'(obs_cyc[k] - c11), 32'(3 + k));
      end

      // Backpressure: fill, stall, then simultaneous pop and push
      step(1'b1, 8'hA1, 1'b0, 1'b0);
      step(1'b1, 8'hA2, 1'b0, 1'b0);
      step(1'b1, 8'hA3, 1'b0, 1'b0);
      step(1'b1, 8'hA4, 1'b0, 1'b0);
      check_eq("bp_full_count", 32'(s_cnt), 32'd3);
      check_eq("bp_full_ready", 32'(s_ir), 32'h0);
      step(1'b1, 8'hA4, 1'b1, 1'b0);
      check_eq("bp_pop_data", 32'(s_od), 32'hA1);
      check_eq("bp_pop_valid", 32'(s_ov), 32'h1);
      check_eq("bp_push_ready", 32'(s_ir), 32'h1);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check_eq("bp_after_count", 32'(s_cnt), 32'd3);
      for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Flush with two items resident and an input offered
      step(1'b1, 8'hB1, 1'b0, 1'b0);
      step(1'b1, 8'hB2, 1'b0, 1'b0);
      step(1'b1, 8'hB3, 1'b1, 1'b1);
      check_eq("flush_count_before", 32'(s_cnt), 32'd2);
      check_eq("flush_in_ready", 32'(s_ir), 32'h0);
      check_eq("flush_out_valid", 32'(s_ov), 32'h0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_eq("flush_count_after", 32'(s_cnt), 32'd0);
      check_eq("flush_valid_after", 32'(s_ov), 32'h0);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0,
              $urandom_range(0, 19) == 0);
      end

      // Asynchronous reset between edges while streaming
      step(1'b1, 8'hC1, 1'b0, 1'b0);
      step(1'b1, 8'hC2, 1'b0, 1'b0);
      @(negedge clk);
      flush = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_out_valid", 32'(out_valid), 32'h0);
      check_eq("arst_count", 32'(count), 32'h0);
      check_eq("arst_out_data", 32'(out_data), 32'h00);
      check_eq("arst_in_ready", 32'(in_ready), 32'h1);
      mpos.delete();
      mdat.delete();
      last_out = 8'h00;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'h5A, 1'b1, 1'b0);
      check_eq("arst_first_accept", 32'(s_acc), 32'h1);
      for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Single-stage instance
      @(negedge clk);
      d1_in_valid = 1'b1; d1_in_data = 8'hD1; d1_out_ready = 1'b0;
      #1;
      check_eq("d1_empty_ready", 32'(d1_in_ready), 32'h1);
      check_eq("d1_empty_count", 32'(d1_count), 32'h0);
      @(negedge clk);
      d1_in_data = 8'hD2;
      #1;
      check_eq("d1_full_stall_ready", 32'(d1_in_ready), 32'h0);
      check_eq("d1_full_count", 32'(d1_count), 32'h1);
      check_eq("d1_full_data", 32'(d1_out_data), 32'hD1);
      @(negedge clk);
      d1_out_ready = 1'b1;
      #1;
      check_eq("d1_pushpop_ready", 32'(d1_in_ready), 32'h1);
      check_eq("d1_pushpop_valid", 32'(d1_out_valid), 32'h1);
      check_eq("d1_pushpop_data", 32'(d1_out_data), 32'hD1);
      @(negedge clk);
      d1_in_valid = 1'b0;
      #1;
      check_eq("d1_after_count", 32'(d1_count), 32'h1);
      check_eq("d1_after_data", 32'(d1_out_data), 32'hD2);
      @(negedge clk);
      #1;
      check_eq("d1_drained_count", 32'(d1_count), 32'h0);
      check_eq("d1_drained_valid", 32'(d1_out_valid), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
